// File: rtl/addr_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : addr_stream_gen
//  Purpose  : Word-address generator. A start pulse latches a word-aligned
//             base byte address and a file size in bytes. The block then
//             issues one word byte-address per accepted beat over a
//             valid/ready handshake. It flags the final beat, pulses done on
//             completion, and pulses err instead of issuing addresses when a
//             request is illegal. An abort ends a running transfer early.
//
//  Ports    : clk          sole clock, rising edge
//             rst_n        synchronous active-low reset
//             start        request pulse, sampled only in IDLE
//             base_addr    start byte address (WORD_BYTES aligned)
//             filesize     transfer length in bytes
//             abort        cancels a transfer in progress
//             addr         current word byte-address
//             addr_valid   addr is valid
//             addr_ready   consumer accepts addr on valid && ready
//             addr_last    high with addr_valid on the final beat
//             beat_count   beats accepted in current / most recent transfer
//             busy         high while a transfer is running
//             done         one-cycle pulse after the last beat is accepted
//             err          one-cycle pulse on a rejected start
//             aborted      one-cycle pulse when abort ends a transfer
//
//  Revision : 1.0  initial release
// ============================================================================
module addr_stream_gen #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned MAX_FILESIZE = 100000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       filesize,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last,
  output logic [31:0]       beat_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted
);

  localparam int unsigned       c_WORD_SHIFT = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] c_ADDR_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [31:0]       c_ROUND_UP   = 32'(WORD_BYTES - 1);
  localparam logic [31:0]       c_MAX_FSIZE  = 32'(MAX_FILESIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] w_cur_addr_nxt;
  logic [31:0]       r_words_left;
  logic [31:0]       w_words_left_nxt;
  logic [31:0]       r_beat_count;
  logic [31:0]       w_beat_count_nxt;

  logic              r_addr_valid;
  logic              w_addr_valid_nxt;
  logic              r_addr_last;
  logic              w_addr_last_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_aborted;
  logic              w_aborted_nxt;

  logic              w_illegal;
  logic [31:0]       w_words_req;

  // Request legality and rounded-up word count. filesize is bounded by
  // MAX_FILESIZE on the legal path, so the 32-bit add cannot overflow there.
  assign w_illegal   = (filesize == 32'd0) ||
                       (filesize > c_MAX_FSIZE) ||
                       (base_addr[c_WORD_SHIFT-1:0] != '0);
  assign w_words_req = (filesize + c_ROUND_UP) >> c_WORD_SHIFT;

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_cur_addr_nxt   = r_cur_addr;
    w_words_left_nxt = r_words_left;
    w_beat_count_nxt = r_beat_count;
    w_addr_valid_nxt = 1'b0;
    w_addr_last_nxt  = 1'b0;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_aborted_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_illegal) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt      = S_RUN;
            w_cur_addr_nxt   = base_addr;
            w_words_left_nxt = w_words_req;
            w_beat_count_nxt = 32'd0;
            w_addr_valid_nxt = 1'b1;
            w_addr_last_nxt  = (w_words_req == 32'd1);
          end
        end
      end

      S_RUN: begin
        // abort wins over a same-cycle handshake; that beat is not counted
        if (abort) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
        end else if (addr_ready) begin
          w_beat_count_nxt = r_beat_count + 32'd1;
          if (r_words_left == 32'd1) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            // address wraps silently modulo 2^ADDR_W
            w_cur_addr_nxt   = r_cur_addr + c_ADDR_STEP;
            w_words_left_nxt = r_words_left - 32'd1;
            w_addr_valid_nxt = 1'b1;
            w_addr_last_nxt  = (r_words_left == 32'd2);
          end
        end else begin
          // stalled: hold the presented beat unchanged
          w_addr_valid_nxt = 1'b1;
          w_addr_last_nxt  = r_addr_last;
        end
      end

      S_DONE: w_state_nxt = S_IDLE;
      S_ERR:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_words_left <= 32'd0;
      r_beat_count <= 32'd0;
      r_addr_valid <= 1'b0;
      r_addr_last  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_addr   <= w_cur_addr_nxt;
      r_words_left <= w_words_left_nxt;
      r_beat_count <= w_beat_count_nxt;
      r_addr_valid <= w_addr_valid_nxt;
      r_addr_last  <= w_addr_last_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  assign addr       = r_cur_addr;
  assign addr_valid = r_addr_valid;
  assign addr_last  = r_addr_last;
  assign beat_count = r_beat_count;
  assign busy       = r_addr_valid;
  assign done       = r_done;
  assign err        = r_err;
  assign aborted    = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_addr_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addr_stream_gen
//  Purpose  : Self-checking bench for addr_stream_gen. Expected beats are
//             queued when a request is driven and popped as the DUT presents
//             them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addr_stream_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] filesize;
  logic        abort;
  logic [31:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic        addr_last;
  logic [31:0] beat_count;
  logic        busy;
  logic        done;
  logic        err;
  logic        aborted;

  int errors = 0;
  int checks = 0;

  // scoreboard entry: {last, addr}
  logic [32:0] sb[$];

  addr_stream_gen #(
    .ADDR_W      (32),
    .WORD_BYTES  (4),
    .MAX_FILESIZE(100000000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .filesize  (filesize),
    .abort     (abort),
    .addr      (addr),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .addr_last (addr_last),
    .beat_count(beat_count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] exp_bc);
    chk({tag, " valid"},   addr_valid, 1'b0);
    chk({tag, " busy"},    busy,       1'b0);
    chk({tag, " done"},    done,       1'b0);
    chk({tag, " err"},     err,        1'b0);
    chk({tag, " aborted"}, aborted,    1'b0);
    chk({tag, " beats"},   beat_count, exp_bc);
  endtask

  // Legal transfer: queue expected beats, drive start, consume with the
  // given ready pattern, then check the done pulse and final beat count.
  task automatic run_xfer(input string tag, input logic [31:0] b, input logic [31:0] fs,
                          input logic [7:0] rdy_pat, input int rdy_len);
    int          words;
    int          cyc;
    logic [32:0] exp;
    words = (int'(fs) + 3) / 4;
    for (int i = 0; i < words; i++) begin
      logic [31:0] a;
      a = b + 32'(4 * i);
      sb.push_back({(i == words - 1), a});
    end
    base_addr  = b;
    filesize   = fs;
    start      = 1'b1;
    addr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (sb.size() > 0 && cyc < 200) begin
      addr_ready = rdy_pat[cyc % rdy_len];
      exp        = sb[0];
      chk({tag, " valid"}, addr_valid, 1'b1);
      chk({tag, " busy"},  busy,       1'b1);
      chk({tag, " addr"},  addr,       exp[31:0]);
      chk({tag, " last"},  addr_last,  exp[32]);
      if (addr_ready) void'(sb.pop_front());
      cyc++;
      @(negedge clk);
    end
    chk({tag, " drained"}, sb.size(), 0);
    sb.delete();
    addr_ready = 1'b0;
    chk({tag, " done"},       done,       1'b1);
    chk({tag, " done valid"}, addr_valid, 1'b0);
    chk({tag, " beats"},      beat_count, 32'(words));
    @(negedge clk);
    chk_idle_outputs({tag, " after"}, 32'(words));
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] b, input logic [31:0] fs,
                             input logic [31:0] exp_bc);
    base_addr = b;
    filesize  = fs;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " err"},   err,        1'b1);
    chk({tag, " valid"}, addr_valid, 1'b0);
    chk({tag, " beats"}, beat_count, exp_bc);
    @(negedge clk);
    chk_idle_outputs({tag, " after"}, exp_bc);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b1;          // reset must override a legal start
    base_addr  = 32'h0000_1000;
    filesize   = 32'd16;
    abort      = 1'b0;
    addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset addr", addr, 32'h0);
    chk("reset last", addr_last, 1'b0);
    chk_idle_outputs("reset", 32'd0);
    start      = 1'b0;
    addr_ready = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);

    // basic streams, ready held high
    run_xfer("xfer16", 32'h0000_1000, 32'd16, 8'h01, 1);
    run_xfer("xfer5",  32'h0000_0020, 32'd5,  8'h01, 1);
    // backpressure: ready 1,0,0,1,0,1
    run_xfer("bp12",   32'h0000_0300, 32'd12, 8'h29, 6);

    // illegal requests leave beat_count at the previous transfer's value
    run_illegal("ill fs0",   32'h0000_0400, 32'd0,         32'd3);
    run_illegal("ill fsbig", 32'h0000_0400, 32'd100000001, 32'd3);
    run_illegal("ill align", 32'h0000_1002, 32'd16,        32'd3);

    // largest legal size is accepted; abort it before any beat completes
    base_addr = 32'h0;
    filesize  = 32'd100000000;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("max err",   err,        1'b0);
    chk("max valid", addr_valid, 1'b1);
    chk("max last",  addr_last,  1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("max aborted", aborted,    1'b1);
    chk("max beats",   beat_count, 32'd0);
    @(negedge clk);

    // abort on the 3rd beat of an 8-word transfer with ready high
    base_addr = 32'h0000_0200;
    filesize  = 32'd32;
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    addr_ready = 1'b1;
    chk("abt b1", addr, 32'h200);
    @(negedge clk);
    chk("abt b2", addr, 32'h204);
    @(negedge clk);
    chk("abt b3", addr, 32'h208);
    abort = 1'b1;
    @(negedge clk);
    abort      = 1'b0;
    addr_ready = 1'b0;
    chk("abt aborted", aborted,    1'b1);
    chk("abt valid",   addr_valid, 1'b0);
    chk("abt busy",    busy,       1'b0);
    chk("abt done",    done,       1'b0);
    chk("abt beats",   beat_count, 32'd2);
    @(negedge clk);
    chk_idle_outputs("abt after", 32'd2);

    // abort outside RUN has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort", aborted, 1'b0);

    // address wrap
    run_xfer("wrap", 32'hFFFF_FFFC, 32'd8, 8'h01, 1);

    // reset during beat 2, with start and abort also asserted
    base_addr = 32'h0000_0500;
    filesize  = 32'd32;
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    addr_ready = 1'b1;
    chk("rst b1", addr, 32'h500);
    @(negedge clk);
    chk("rst b2", addr, 32'h504);
    rst_n     = 1'b0;
    start     = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    chk("rst mid addr", addr, 32'h0);
    chk("rst mid last", addr_last, 1'b0);
    chk_idle_outputs("rst mid", 32'd0);
    rst_n      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    addr_ready = 1'b0;
    @(negedge clk);
    run_xfer("post rst", 32'h0000_0040, 32'd4, 8'h01, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
